// File: rtl/img_binner.sv
// Crops one armed grayscale frame to a 28*BIN square window and box-averages it
// into 784 normalized 9-bit pixels, emitted in raster order on a one-cycle strobe.
module img_binner #(
    parameter int unsigned SRC_W  = 1280,
    parameter int unsigned SRC_H  = 960,
    parameter int unsigned X_OFF  = 192,
    parameter int unsigned Y_OFF  = 32,
    parameter int unsigned BIN    = 32,
    parameter int unsigned INVERT = 1
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        i_arm,
    input  logic        i_fval,
    input  logic        i_dval,
    input  logic [11:0] i_gray,
    output logic [8:0]  o_pxl,
    output logic        o_dval,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_short
);

    localparam int unsigned LOG_BIN = $clog2(BIN);
    localparam int unsigned WIN     = 28 * BIN;
    localparam int unsigned AW      = 12 + 2 * LOG_BIN;
    localparam int unsigned XW      = $clog2(SRC_W + 1);
    localparam int unsigned YW      = $clog2(SRC_H + 1);
    localparam int unsigned NPIX    = 784;

    typedef enum logic [2:0] {
        StIdle,
        StWaitLow,
        StWaitHigh,
        StAccum,
        StFinish
    } state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [9:0]      cnt_q, cnt_d;
    logic [8:0]      pxl_q, pxl_d;
    logic            dval_q, dval_d;
    logic            done_q, done_d;
    logic            short_q, short_d;
    logic [AW-1:0]   acc_q [28];

    logic                pix_ok;
    logic                in_win;
    logic [XW-1:0]       x_rel;
    logic [LOG_BIN-1:0]  y_lo;
    logic [4:0]          idx;
    logic                last_x;
    logic                last_y;
    logic                emit;
    logic [AW-1:0]       sum;
    logic [8:0]          avg;
    logic                acc_clr;
    logic                acc_we;

    always_comb begin
        pix_ok = (state_q == StAccum) && i_fval && i_dval;
        in_win = (x_q >= XW'(X_OFF)) && (x_q < XW'(X_OFF + WIN)) &&
                 (y_q >= YW'(Y_OFF)) && (y_q < YW'(Y_OFF + WIN));
        x_rel  = x_q - XW'(X_OFF);
        y_lo   = LOG_BIN'(y_q - YW'(Y_OFF));
        idx    = 5'(x_rel >> LOG_BIN);
        last_x = &x_rel[LOG_BIN-1:0];
        last_y = &y_lo;
        emit   = pix_ok && in_win && last_x && last_y;
        sum    = acc_q[idx] + AW'(i_gray);
        // Dividing by BIN*BIN then by 8 maps the 12-bit mean onto 9 bits.
        avg    = sum[AW-1 -: 9];
        acc_clr = (state_q == StIdle) && i_arm && !done_q;
        acc_we  = pix_ok && in_win;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        pxl_d   = pxl_q;
        dval_d  = 1'b0;
        done_d  = 1'b0;
        short_d = short_q;
        unique case (state_q)
            StIdle: begin
                // done_q guard keeps an arm coinciding with o_done from being taken.
                if (i_arm && !done_q) begin
                    state_d = StWaitLow;
                    short_d = 1'b0;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            StWaitLow: begin
                if (!i_fval) state_d = StWaitHigh;
            end
            StWaitHigh: begin
                if (i_fval) begin
                    state_d = StAccum;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            StAccum: begin
                if (!i_fval) begin
                    short_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (i_dval) begin
                    if (x_q == XW'(SRC_W - 1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (emit) begin
                        pxl_d  = (INVERT != 0) ? (9'd511 - avg) : avg;
                        dval_d = 1'b1;
                        cnt_d  = cnt_q + 10'd1;
                        if (cnt_q == 10'(NPIX - 1)) state_d = StFinish;
                    end
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            pxl_q   <= '0;
            dval_q  <= 1'b0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            pxl_q   <= pxl_d;
            dval_q  <= dval_d;
            done_q  <= done_d;
            short_q <= short_d;
        end
    end

    // Completing pixel clears its entry so the next band starts from zero.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 28; i++) acc_q[i] <= '0;
        end else if (acc_clr) begin
            for (int i = 0; i < 28; i++) acc_q[i] <= '0;
        end else if (acc_we) begin
            acc_q[idx] <= emit ? '0 : sum;
        end
    end

    assign o_pxl   = pxl_q;
    assign o_dval  = dval_q;
    assign o_busy  = (state_q != StIdle);
    assign o_done  = done_q;
    assign o_short = short_q;

endmodule
